// File: rtl/cas_scheduler.sv
// CAS command scheduler: enforces tCCD / write-to-read / read-to-write spacing,
// tracks issued CAS commands until their data window opens, and drives the burst strobes.
module cas_scheduler #(
  parameter int RD_DELAY = 11,
  parameter int WR_DELAY = 9,
  parameter int BL       = 8,
  parameter int TCCD     = 4,
  parameter int TWTR     = 6,
  parameter int TRTW     = 8,
  parameter int QDEPTH   = 4
) (
  input  logic clock_t,
  input  logic reset_n,
  input  logic req_valid,
  input  logic req_rw,
  output logic req_ready,
  output logic cas_rdy,
  output logic cas_rw,
  output logic data_start,
  output logic data_valid,
  output logic data_rw,
  output logic idle,
  output logic protocol_err
);

  localparam int HALF   = BL / 2;
  localparam int BEAT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int OCC_W  = $clog2(QDEPTH + 1);
  localparam int IDX_W  = $clog2(QDEPTH);
  localparam int W2R    = WR_DELAY + HALF + TWTR;
  localparam logic [7:0] RD_CNT0 = 8'(RD_DELAY - 1);
  localparam logic [7:0] WR_CNT0 = 8'(WR_DELAY - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(HALF - 1);
  // Entries can only collide when pushed at different cycles with different delays,
  // so the type with the longer delay is always the older one.
  localparam logic OLD_RW = (WR_DELAY > RD_DELAY) ? 1'b1 : 1'b0;

  typedef enum logic {D_IDLE = 1'b0, D_BURST = 1'b1} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic reached(input logic [7:0] since, input int gap);
    return (int'(since) + 1) >= gap;
  endfunction

  logic [7:0]       since_any, since_rd, since_wr;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] pop_n_p1;
  logic [QDEPTH-1:0] tbl_vld;
  logic             tbl_rw  [QDEPTH];
  logic [7:0]       tbl_cnt [QDEPTH];
  logic [IDX_W-1:0] free_idx;
  logic [OCC_W-1:0] exp_n;
  logic             exp_rd, exp_wr, exp_any, exp_rw;
  logic             rd_ok, wr_ok, accept;
  state_t           state;
  logic [BEAT_W-1:0] beat;

  assign rd_ok     = reached(since_any, TCCD) && reached(since_wr, W2R);
  assign wr_ok     = reached(since_any, TCCD) && reached(since_rd, TRTW);
  assign req_ready = reset_n && (req_rw ? wr_ok : rd_ok) && (occ < OCC_W'(QDEPTH));
  assign accept    = req_valid && req_ready;
  assign idle      = (occ == '0) && (state == D_IDLE);

  always_comb begin
    logic found;
    found    = 1'b0;
    free_idx = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (!found && !tbl_vld[i]) begin
        free_idx = IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    exp_n  = '0;
    exp_rd = 1'b0;
    exp_wr = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (tbl_vld[i] && tbl_cnt[i] == 8'd0) begin
        exp_n = exp_n + OCC_W'(1);
        if (tbl_rw[i]) exp_wr = 1'b1;
        else           exp_rd = 1'b1;
      end
    end
    exp_any = exp_rd | exp_wr;
    exp_rw  = (exp_rd && exp_wr) ? OLD_RW : exp_wr;
  end

  // Stage p0: accept -> CAS issue, spacing counters, occupancy
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      since_any <= 8'hFF;
      since_rd  <= 8'hFF;
      since_wr  <= 8'hFF;
      cas_rdy   <= 1'b0;
      cas_rw    <= 1'b0;
      occ       <= '0;
      pop_n_p1  <= '0;
    end else begin
      since_any <= accept ? 8'd0 : sat_inc(since_any);
      since_rd  <= (accept && !req_rw) ? 8'd0 : sat_inc(since_rd);
      since_wr  <= (accept && req_rw) ? 8'd0 : sat_inc(since_wr);
      cas_rdy   <= accept;
      if (accept) cas_rw <= req_rw;
      pop_n_p1  <= exp_n;
      occ       <= occ + OCC_W'(accept) - pop_n_p1;
    end
  end

  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      tbl_vld <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (accept && free_idx == IDX_W'(i))
          tbl_vld[i] <= 1'b1;
        else if (tbl_vld[i] && tbl_cnt[i] == 8'd0)
          tbl_vld[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock_t) begin
    for (int i = 0; i < QDEPTH; i++) begin
      if (accept && free_idx == IDX_W'(i)) begin
        tbl_rw[i]  <= req_rw;
        tbl_cnt[i] <= req_rw ? WR_CNT0 : RD_CNT0;
      end else if (tbl_cnt[i] != 8'd0) begin
        tbl_cnt[i] <= tbl_cnt[i] - 8'd1;
      end
    end
  end

  // Stage p1: expiry -> data window strobes
  always_ff @(posedge clock_t or negedge reset_n) begin
    if (!reset_n) begin
      state        <= D_IDLE;
      beat         <= '0;
      data_start   <= 1'b0;
      data_valid   <= 1'b0;
      data_rw      <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      data_start <= 1'b0;
      if (exp_n > OCC_W'(1)) protocol_err <= 1'b1;
      case (state)
        D_IDLE: begin
          if (exp_any) begin
            state      <= D_BURST;
            beat       <= '0;
            data_valid <= 1'b1;
            data_rw    <= exp_rw;
            data_start <= 1'b1;
          end
        end
        D_BURST: begin
          if (beat == LAST_BEAT) begin
            if (exp_any) begin
              beat       <= '0;
              data_rw    <= exp_rw;
              data_start <= 1'b1;
            end else begin
              state      <= D_IDLE;
              data_valid <= 1'b0;
            end
          end else begin
            beat <= beat + BEAT_W'(1);
            if (exp_any) protocol_err <= 1'b1;
          end
        end
        default: state <= D_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cas_scheduler.sv
// Bench for cas_scheduler: a timeline model of accepts predicts every output each cycle,
// and directed scenarios pin absolute latencies and spacings with literal offsets.
module tb_cas_scheduler;

  localparam int RD_DELAY = 11;
  localparam int WR_DELAY = 9;
  localparam int BL       = 8;
  localparam int TCCD     = 4;
  localparam int TWTR     = 6;
  localparam int TRTW     = 8;
  localparam int QDEPTH   = 4;
  localparam int HALF     = BL / 2;
  localparam int WRGAP    = WR_DELAY + HALF + TWTR;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic req_valid = 1'b0, req_rw = 1'b0;
  logic req_ready, cas_rdy, cas_rw, data_start, data_valid, data_rw, idle, protocol_err;
  logic q_valid = 1'b0, q_rw = 1'b0;
  logic q_ready, q_cas_rdy, q_cas_rw, q_start, q_dvalid, q_drw, q_idle, q_perr;

  always #5 clk = ~clk;

  cas_scheduler u_dut (
    .clock_t(clk), .reset_n(reset_n), .req_valid(req_valid), .req_rw(req_rw),
    .req_ready(req_ready), .cas_rdy(cas_rdy), .cas_rw(cas_rw), .data_start(data_start),
    .data_valid(data_valid), .data_rw(data_rw), .idle(idle), .protocol_err(protocol_err)
  );

  cas_scheduler #(.QDEPTH(2)) u_dut_q2 (
    .clock_t(clk), .reset_n(reset_n), .req_valid(q_valid), .req_rw(q_rw),
    .req_ready(q_ready), .cas_rdy(q_cas_rdy), .cas_rw(q_cas_rw), .data_start(q_start),
    .data_valid(q_dvalid), .data_rw(q_drw), .idle(q_idle), .protocol_err(q_perr)
  );

  typedef struct {int t; bit rw;} acc_s;
  acc_s hist[$];
  int   m_c = 0;
  bit   m_ready = 1'b0;
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, m_c);
    end
  endtask

  always @(posedge clk) begin
    if (reset_n && req_valid && m_ready) hist.push_back('{m_c, req_rw});
    m_c <= m_c + 1;
  end

  always @(negedge reset_n) hist.delete();

  // Timeline model: everything follows from the list of accept cycles and types.
  always @(negedge clk) begin : model_cmp
    int c, l_any, l_rd, l_wr, outst, st;
    bit e_cas, e_rw, e_ds, e_dv, e_drw, e_busy, ok;
    c = m_c; l_any = -1000; l_rd = -1000; l_wr = -1000; outst = 0;
    e_cas = 0; e_rw = 0; e_ds = 0; e_dv = 0; e_drw = 0; e_busy = 0;
    foreach (hist[i]) begin
      st = hist[i].t + 1 + (hist[i].rw ? WR_DELAY : RD_DELAY);
      l_any = hist[i].t;
      if (hist[i].rw) l_wr = hist[i].t; else l_rd = hist[i].t;
      e_rw = hist[i].rw;
      if (hist[i].t == c - 1) e_cas = 1;
      if (c == st) e_ds = 1;
      if (c >= st && c < st + HALF) begin e_dv = 1; e_drw = hist[i].rw; end
      if (c > hist[i].t && c <= st) outst++;
      if (c > hist[i].t && c < st + HALF) e_busy = 1;
    end
    ok = (c - l_any >= TCCD) && (req_rw ? (c - l_rd >= TRTW) : (c - l_wr >= WRGAP))
         && (outst < QDEPTH);
    m_ready = reset_n && ok;
    chk("req_ready", req_ready, m_ready);
    chk("cas_rdy", cas_rdy, e_cas);
    chk("cas_rw", cas_rw, e_rw);
    chk("data_start", data_start, e_ds);
    chk("data_valid", data_valid, e_dv);
    if (e_dv || !reset_n) chk("data_rw", data_rw, e_drw);
    chk("idle", idle, !e_busy);
    chk("protocol_err", protocol_err, 0);
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int c);
    int k;
    k = 0;
    @(negedge clk);
    while (m_c < c && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (m_c != c) chk("at_cycle", m_c, c);
  endtask

  task automatic issue(input bit rw, output int t);
    t = -1;
    req_valid = 1'b1;
    req_rw = rw;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (m_ready) begin
        t = m_c;
        break;
      end
    end
    #1 req_valid = 1'b0;
    if (t < 0) chk("accept_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", m_c);
    $fatal(1);
  end

  initial begin : stim
    int t0, t1, a[4];
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_idle", idle, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_data_valid", data_valid, 0);
    sync();
    reset_n = 1'b1;
    repeat (2) sync();

    // Single read
    issue(0, t0);
    at_cycle(t0 + 1);
    chk("s1_cas_rdy", cas_rdy, 1);
    chk("s1_cas_rw", cas_rw, 0);
    at_cycle(t0 + 11); chk("s1_dv_before", data_valid, 0);
    at_cycle(t0 + 12); chk("s1_start", data_start, 1); chk("s1_dv_first", data_valid, 1);
    at_cycle(t0 + 15); chk("s1_dv_last", data_valid, 1); chk("s1_idle_busy", idle, 0);
    at_cycle(t0 + 16); chk("s1_dv_after", data_valid, 0); chk("s1_idle", idle, 1);
    repeat (30) sync();

    // Reads held continuously
    for (int i = 0; i < 4; i++) issue(0, a[i]);
    chk("s2_gap1", a[1] - a[0], 4);
    chk("s2_gap2", a[2] - a[0], 8);
    chk("s2_gap3", a[3] - a[0], 12);
    at_cycle(a[0] + 16); chk("s2_b2b_start", data_start, 1); chk("s2_b2b_dv", data_valid, 1);
    at_cycle(a[0] + 27); chk("s2_last_dv", data_valid, 1);
    at_cycle(a[0] + 28); chk("s2_end_dv", data_valid, 0);
    repeat (30) sync();

    // Write then read
    issue(1, t0);
    fork
      issue(0, t1);
      begin
        at_cycle(t0 + 10); chk("s3_wr_dv", data_valid, 1); chk("s3_wr_rw", data_rw, 1);
        at_cycle(t0 + 13); chk("s3_wr_dv_last", data_valid, 1);
        at_cycle(t0 + 14); chk("s3_wr_dv_end", data_valid, 0);
      end
    join
    chk("s3_w2r_gap", t1 - t0, 19);
    at_cycle(t0 + 31); chk("s3_rd_start", data_start, 1); chk("s3_rd_rw", data_rw, 0);
    at_cycle(t0 + 34); chk("s3_rd_dv_last", data_valid, 1);
    repeat (30) sync();

    // Read then write
    issue(0, t0);
    issue(1, t1);
    chk("s4_r2w_gap", t1 - t0, 8);
    at_cycle(t0 + 12); chk("s4_rd_dv", data_valid, 1); chk("s4_rd_rw", data_rw, 0);
    at_cycle(t0 + 18); chk("s4_wr_start", data_start, 1); chk("s4_wr_rw", data_rw, 1);
    at_cycle(t0 + 21); chk("s4_wr_dv_last", data_valid, 1);
    at_cycle(t0 + 22); chk("s4_wr_dv_end", data_valid, 0);
    repeat (30) sync();

    // Reset during an in-flight read
    issue(0, t0);
    at_cycle(t0 + 4);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("s5_idle", idle, 1);
    chk("s5_cas_rdy", cas_rdy, 0);
    chk("s5_req_ready", req_ready, 0);
    chk("s5_data_valid", data_valid, 0);
    sync();
    reset_n = 1'b1;
    sync();
    issue(0, t1);
    chk("s5_accept_cycle", t1 - t0, 7);
    at_cycle(t0 + 12); chk("s5_no_start", data_start, 0);
    at_cycle(t0 + 19); chk("s5_new_start", data_start, 1);
    repeat (30) sync();

    // Two-entry table: accepts at 0, 4, 13
    q_rw = 1'b0;
    q_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk($sformatf("q2_ready_%0d", k), q_ready, (k == 0 || k == 4 || k == 13) ? 1 : 0);
    end
    @(posedge clk);
    #1 q_valid = 1'b0;
    repeat (40) sync();
    chk("q2_idle", q_idle, 1);
    chk("q2_perr", q_perr, 0);
    chk("q2_cas_rdy", q_cas_rdy, 0);
    chk("q2_cas_rw", q_cas_rw, 0);
    chk("q2_start", q_start, 0);
    chk("q2_dvalid", q_dvalid, 0);
    chk("q2_drw", q_drw, 0);
    chk("end_perr", protocol_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cas_scheduler.md
# cas_scheduler

Sequences read/write CAS commands toward the burst read/write data engine. It accepts requests from the bank/command front end and enforces the CAS-to-CAS spacing rules tCCD, write-to-read and read-to-write turnaround. It tracks outstanding CAS commands in a small in-flight table and generates the data-window strobes at the configured CAS/CWL latency. The data bursts it drives never overlap, so the data path needs no tracking queue of its own.

## Interface
- RD_DELAY, 11: cycles from CAS issue to first read data cycle (AL+CL); 1..200
- WR_DELAY, 9: cycles from CAS issue to first write data cycle (AL+CWL); 1..200
- BL, 8: burst length in beats; data window = BL/2 clocks
- TCCD, 4: minimum cycles between any two accepted requests; must be >= BL/2
- TWTR, 6: cycles after end of write data before a read CAS may issue
- TRTW, 8: minimum cycles from read accept to next write accept
- QDEPTH, 4: in-flight table entries (CAS issued, data not yet started); 2..8
- clock_t  in  1  main clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  front end presents a CAS request
- req_rw  in  1  0 = READ, 1 = WRITE
- req_ready  out  1  request accepted on the cycle where req_valid & req_ready
- cas_rdy  out  1  one-cycle pulse: CAS issued (registered, cycle after accept)
- cas_rw  out  1  type of CAS on cas_rdy; holds its last value otherwise
- data_start  out  1  one-cycle pulse on first data cycle of a burst
- data_valid  out  1  high for BL/2 cycles of each burst
- data_rw  out  1  type of the current burst; valid while data_valid
- idle  out  1  table empty and no burst active
- protocol_err  out  1  sticky: two entries expired in the same cycle, or a start occurred during a burst

## Operation
- Spacing counters: since_any, since_rd and since_wr are 8-bit counters counting cycles since the last accept of any type, of a read and of a write. They saturate at 255. They reset to 255, so the first request after reset is accepted immediately.
- A READ is allowed when since_any+1 >= TCCD and since_wr+1 >= WR_DELAY+BL/2+TWTR.
- A WRITE is allowed when since_any+1 >= TCCD and since_rd+1 >= TRTW.
- req_ready = allowed(req_rw) and occupancy < QDEPTH. req_ready is a combinational function of registered state and req_rw. The front end must hold req_valid and req_rw until accepted.
- On accept: clear the matching counters, register cas_rdy=1 and cas_rw=req_rw, and push an entry {rw, count = delay-1} into the first free table slot.
- In-flight table: each valid entry's count decrements every cycle. An entry whose count = 0 produces data_start that cycle, loads the burst FSM, and frees the slot at the clock edge. Occupancy is registered, so a slot freed in cycle N is usable for acceptance in cycle N+1.
- Push and pop in the same cycle leave occupancy unchanged. When the table is full, req_ready stays 0 even if a pop happens that cycle.
- Burst FSM states:
  - D_IDLE -> D_BURST on any entry expiring.
  - D_BURST holds data_valid=1 for BL/2 cycles using a beat counter.
  - D_BURST -> D_BURST if a new entry expires on its last cycle (back-to-back bursts).
  - D_BURST -> D_IDLE otherwise.
- Entry expiring during D_BURST other than on its last cycle, or two entries expiring together: set protocol_err. The oldest entry wins and the other is dropped. Correct parameters make this unreachable.
- idle = (occupancy == 0) and state == D_IDLE.

## Timing
- Reset values: req_ready 0 while reset_n is low; cas_rdy 0; cas_rw 0; data_start 0; data_valid 0; data_rw 0; idle 1; protocol_err 0; table empty; counters 255; FSM D_IDLE.
- Reset mid-operation: the table, FSM and counters clear immediately (asynchronous). Outstanding bursts are abandoned with no strobes.
- Request accepted in cycle T:
  - cas_rdy in cycle T+1.
  - data_start in cycle T+1+delay.
  - data_valid in cycles T+1+delay .. T+delay+BL/2.
- Minimum accept spacing: TCCD cycles for same type. Write->read spacing is WR_DELAY+BL/2+TWTR. Read->write spacing is max(TCCD, TRTW).

## Test plan
- Single READ accepted cycle 0 (defaults) -> cas_rdy cycle 1 with cas_rw=0, data_start cycle 12, data_valid cycles 12-15, idle high again cycle 16.
- READs held valid continuously -> accepts at 0, 4, 8, 12; data bursts at 12-15, 16-19, 20-23, 24-27 contiguous; protocol_err stays 0.
- QDEPTH=2, READs held valid -> accepts at 0 and 4; req_ready 0 cycles 8-12; third accept cycle 13.
- WRITE accepted at 0, then READ held valid -> write data 10-13; read accepted cycle 19 earliest; read data 31-34.
- READ accepted at 0, then WRITE held valid -> write accepted cycle 8; write data 18-21 after read data 12-15.
- reset_n low at cycle 5 during an in-flight READ -> all outputs return to reset values immediately; no data_start at cycle 12; a request at cycle 7 after release is accepted.
